// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - step-paced load/add/shift sequencer owning the accumulator
// Optional saturating ADD with sticky overflow: define ACCUM_SEQ_SATURATE_EN.
module accum_sequencer #(
    parameter int WIDTH    = 5,
    parameter int DIV_BITS = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [3:0]       count,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [3:0]       remaining,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_BITS-1:0] r_presc;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    r_operand;
    logic [1:0]          r_sel;
    logic [3:0]          r_rem;
    logic                w_step;
    logic [WIDTH-1:0]    w_step_acc;

    // A step fires on the edge where the prescaler wraps back to zero.
    assign w_step = (r_state == S_RUN) && (&r_presc);

`ifdef ACCUM_SEQ_SATURATE_EN
    logic [WIDTH:0] w_sum;
    logic           w_step_ovf;
    logic           r_ovf;
    assign w_sum = {1'b0, r_acc} + {1'b0, r_operand};
`else
    logic [WIDTH-1:0] w_sum;
    assign w_sum = r_acc + r_operand;
`endif

    always_comb begin
        w_step_acc = r_acc;
`ifdef ACCUM_SEQ_SATURATE_EN
        w_step_ovf = 1'b0;
`endif
        case (r_sel)
            2'b00: w_step_acc = r_operand;
            2'b01: begin
`ifdef ACCUM_SEQ_SATURATE_EN
                if (w_sum[WIDTH]) begin
                    w_step_acc = '1;
                    w_step_ovf = 1'b1;
                end else begin
                    w_step_acc = w_sum[WIDTH-1:0];
                end
`else
                w_step_acc = w_sum;
`endif
            end
            2'b10: w_step_acc = {r_acc[WIDTH-2:0], 1'b0};
            default: w_step_acc = {1'b0, r_acc[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = (count == 4'd0) ? S_DONE : S_RUN;
                S_RUN:  if (w_step && (r_rem == 4'd1)) w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_sel     <= 2'b00;
            r_rem     <= 4'd0;
            r_presc   <= '0;
        end else if (clear) begin
            r_acc     <= '0;
            r_sel     <= 2'b00;
            r_rem     <= 4'd0;
            r_presc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel     <= op;
                        r_operand <= operand;
                        r_rem     <= count;
                        r_presc   <= '0;
                    end
                end
                S_RUN: begin
                    r_presc <= r_presc + DIV_BITS'(1);
                    if (w_step) begin
                        r_acc <= w_step_acc;
                        r_rem <= r_rem - 4'd1;
                    end
                end
                S_DONE: r_sel <= 2'b00;
                default: r_sel <= 2'b00;
            endcase
        end
    end

`ifdef ACCUM_SEQ_SATURATE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (clear || ((r_state == S_IDLE) && start)) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_step_ovf) begin
            r_ovf <= 1'b1;
        end
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign acc       = r_acc;
    assign sel       = r_sel;
    assign remaining = r_rem;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - vector table plus step scoreboard for accum_sequencer
module tb_accum_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, clear;
    logic [1:0] op;
    logic [4:0] operand;
    logic [3:0] count;
    logic [4:0] acc;
    logic [1:0] sel;
    logic       busy, done, ovf;
    logic [3:0] remaining;

    accum_sequencer #(.WIDTH(5), .DIV_BITS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .op(op),
        .operand(operand), .count(count), .acc(acc), .sel(sel), .busy(busy),
        .done(done), .remaining(remaining), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [4:0] acc;
        logic [3:0] rem;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [4:0] opnd;
        logic [3:0] cnt;
        logic [4:0] fin;
        bit         poke;
    } vec_t;

    exp_t       sb[$];
    exp_t       m_e;
    vec_t       vecs[10];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         last_done = -1;
    logic [3:0] prev_rem = 4'd0;
    logic [4:0] m_acc = 5'd0;
    logic       m_ovf = 1'b0;
    int         e0, d0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void mstep(input logic [1:0] o, input logic [4:0] d);
        int s;
        case (o)
            2'b00: m_acc = d;
            2'b01: begin
                s = int'(m_acc) + int'(d);
`ifdef ACCUM_SEQ_SATURATE_EN
                if (s > 31) begin
                    m_acc = 5'd31;
                    m_ovf = 1'b1;
                end else begin
                    m_acc = 5'(s);
                end
`else
                m_acc = 5'(s % 32);
`endif
            end
            2'b10: m_acc = {m_acc[3:0], 1'b0};
            default: m_acc = {1'b0, m_acc[4:1]};
        endcase
    endfunction

    // A step is recognised by remaining counting down while busy.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && (remaining < prev_rem)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_step", sb.size(), 1);
                end else begin
                    m_e = sb.pop_front();
                    chk("step_cycle", cyc, m_e.cyc);
                    chk("step_acc", acc, m_e.acc);
                    chk("step_rem", remaining, m_e.rem);
                    chk("step_ovf", ovf, m_e.ovf);
                end
            end
            if (done) begin
                done_cnt++;
                last_done = cyc;
            end
        end
        prev_rem = remaining;
    end

    task automatic run_cmd(input logic [1:0] o, input logic [4:0] d, input logic [3:0] c,
                           input logic [4:0] fin, input bit poke);
        int s0, dc0;
        start   = 1'b1;
        op      = o;
        operand = d;
        count   = c;
        s0      = cyc + 1;
        dc0     = done_cnt;
        m_ovf   = 1'b0;
        for (int k = 1; k <= int'(c); k++) begin
            mstep(o, d);
            sb.push_back('{s0 + 4 * k, m_acc, 4'(int'(c) - k), m_ovf});
        end
        for (int i = 0; i < 4 * int'(c) + 1; i++) begin
            @(negedge clk);
            start = poke && (i == 1);
            if (poke && i == 1) begin
                op      = 2'b00;
                operand = 5'd0;
                count   = 4'd1;
            end
            if (i == 0) begin
                chk("busy_after_start", busy, 1);
                chk("sel_captured", sel, o);
                chk("remaining_loaded", remaining, c);
            end
        end
        @(negedge clk);
        #1;
        chk("busy_cleared", busy, 0);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("done_cycle", last_done, s0 + 4 * int'(c));
        chk("final_acc", acc, fin);
        chk("final_ovf", ovf, m_ovf);
        chk("sel_idle", sel, 0);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        clear   = 1'b0;
        op      = 2'b00;
        operand = 5'd0;
        count   = 4'd0;

        vecs[0] = '{2'b00, 5'd19, 4'd1, 5'd19, 1'b0};
`ifdef ACCUM_SEQ_SATURATE_EN
        vecs[1] = '{2'b01, 5'd7,  4'd3, 5'd31, 1'b1};
`else
        vecs[1] = '{2'b01, 5'd7,  4'd3, 5'd8,  1'b1};
`endif
        vecs[2] = '{2'b00, 5'd19, 4'd1, 5'd19, 1'b0};
        vecs[3] = '{2'b10, 5'd0,  4'd1, 5'd6,  1'b0};
        vecs[4] = '{2'b11, 5'd0,  4'd2, 5'd1,  1'b0};
        vecs[5] = '{2'b00, 5'd9,  4'd0, 5'd1,  1'b0};
        vecs[6] = '{2'b01, 5'd31, 4'd2, 5'd31, 1'b0};
        vecs[7] = '{2'b00, 5'd21, 4'd1, 5'd21, 1'b0};
        vecs[8] = '{2'b10, 5'd0,  4'd3, 5'd8,  1'b0};
        vecs[9] = '{2'b01, 5'd1,  4'd15, 5'd23, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_acc", acc, 0);
        chk("reset_sel", sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_remaining", remaining, 0);
        chk("reset_ovf", ovf, 0);
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            run_cmd(vecs[v].op, vecs[v].opnd, vecs[v].cnt, vecs[v].fin, vecs[v].poke);
        end

        // Abort: clear lands on E0+6 of an ADD run, then a start the very next cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand = 5'd3; count = 4'd3;
        e0 = cyc + 1;
        d0 = done_cnt;
        m_ovf = 1'b0;
        mstep(2'b01, 5'd3);
        sb.push_back('{e0 + 4, m_acc, 4'd2, m_ovf});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            clear = (i == 5);
        end
        @(negedge clk);
        chk("abort_acc", acc, 0);
        chk("abort_busy", busy, 0);
        chk("abort_remaining", remaining, 0);
        chk("abort_done_seen", done_cnt - d0, 0);
        chk("abort_sb_drained", sb.size(), 0);
        clear = 1'b0;
        m_acc = 5'd0;
        run_cmd(2'b00, 5'd13, 4'd1, 5'd13, 1'b0);

        // Asynchronous reset between edges in the middle of a run.
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand = 5'd2; count = 4'd3;
        e0 = cyc + 1;
        d0 = done_cnt;
        m_ovf = 1'b0;
        mstep(2'b01, 5'd2);
        sb.push_back('{e0 + 4, m_acc, 4'd2, m_ovf});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_acc", acc, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_remaining", remaining, 0);
        chk("async_sel", sel, 0);
        chk("async_ovf", ovf, 0);
        chk("async_sb_drained", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        m_acc = 5'd0;
        repeat (6) @(negedge clk);
        chk("post_reset_acc", acc, 0);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_done_seen", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Controller that sequences the 5-bit accumulate/shift datapath: owns the accumulator register, selects one of four operations (load, add, shift left, shift right), and repeats that operation a programmed number of times. Each repetition happens on a slow step tick from an internal prescaler, so results can be watched on LEDs. It sits between the board inputs (switches and keys, which supply the command) and the LED outputs (which show the accumulator).

## Interface
- `WIDTH`, 5: accumulator and operand width.
- `DIV_BITS`, 26: prescaler width. One step every 2^DIV_BITS clock cycles. Use 2 in simulation.

- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: command request; sampled only in IDLE.
- `clear`  in  1: synchronous abort. Sets acc to 0 and returns to IDLE from any state.
- `op`  in  2: operation code. 00 LOAD, 01 ADD, 10 SHL, 11 SHR.
- `operand`  in  WIDTH: data for LOAD/ADD; captured at start.
- `count`  in  4: number of steps; captured at start.
- `acc`  out  WIDTH: accumulator value.
- `sel`  out  2: captured op while busy; 00 in IDLE.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: high for exactly one cycle, in DONE.
- `remaining`  out  4: steps left.
- `ovf`  out  1: sticky overflow flag (see Configuration).

## Operation
- Reset values: state IDLE, acc 0, sel 0, busy 0, done 0, remaining 0, ovf 0, prescaler 0.
- States: IDLE, RUN, DONE.
- **IDLE**
  - If `start` is high at edge E0 (and `clear` is low):
    - capture op, operand and count; set remaining = count;
    - clear the prescaler and ovf;
    - go to RUN, or go to DONE if count = 0.
- **RUN**
  - Prescaler increments every cycle.
  - When prescaler = 2^DIV_BITS−1 (it then wraps to 0), one step executes at that edge:
    - LOAD: acc ← operand.
    - ADD: acc ← acc + operand, mod 2^WIDTH unless saturating.
    - SHL: acc ← acc << 1, zero-fill, MSB discarded.
    - SHR: acc ← acc >> 1, logical shift.
  - remaining decrements on each step. When it reaches 0 at that same edge, go to DONE.
- **DONE**
  - done = 1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `clear` has priority over `start` and over a step at the same edge. It sets acc 0, remaining 0, ovf 0, state IDLE. `done` is not pulsed.
- `reset` mid-operation: immediate return to the reset values; no done pulse.
- acc holds its value in IDLE and DONE, and between steps.

## Timing
- With start accepted at E0, step k takes effect at edge E0 + k·2^DIV_BITS.
- The last step's edge E_last moves the FSM to DONE. done is high during the cycle after E_last; busy falls at E_last+1.
- count = 0: busy and done are high for the single cycle after E0; acc is unchanged.
- A new start is accepted at the earliest at the edge where the FSM is already back in IDLE, i.e. E_last+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ACCUM_SEQ_SATURATE_EN` defined:
  - ADD clamps to 2^WIDTH−1 when the true sum exceeds it.
  - ovf is set and stays set until the next accepted start, a clear, or reset.
- `ACCUM_SEQ_SATURATE_EN` undefined:
  - ADD wraps modulo 2^WIDTH.
  - ovf is tied to 0.
- Shifts are unaffected in both builds.

## Test plan
(WIDTH=5, DIV_BITS=2.)
- **LOAD:** op=00, operand=19, count=1, start at E0 → acc=19 at E0+4; done=1 in the following cycle only; busy=0 after E0+5.
- **ADD repeat:** from acc=19, op=01, operand=7, count=3 → acc 26, 1, 8 at E0+4/8/12 with ovf=0 (macro off). With the macro on → acc 26, 31, 31 and ovf=1 from E0+8.
- **Shifts:**
  - acc=5'b10011, op=10, count=1 → acc=5'b00110.
  - Then op=11, count=2 → acc 5'b00011, then 5'b00001.
  - remaining steps 2→1→0.
- **Zero count / busy start:**
  - count=0 → done at E0+1, acc unchanged.
  - start pulsed at E0+2 of a count=3 run → ignored; exactly 3 steps occur.
- **Abort:** clear asserted at E0+6 of an ADD count=3 run → acc=0, busy=0, no done pulse. A new start in the next cycle is accepted.
- **Async reset:** reset raised between clock edges during RUN → outputs reach their reset values immediately. After release, the next step edge produces no step.
